// File: rtl/mem_dpi_pkg.sv
// rtl/mem_dpi_pkg.sv - state types, constants and pmem access functions for mem_dpi_hs
package mem_dpi_pkg;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    localparam int WORD_BYTES = 4;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // Simulated physical memory: word-aligned byte address -> 32-bit word, plus call counters.
    logic [31:0] pmem_mem [logic [31:0]];
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;

    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        pmem_rd_calls = pmem_rd_calls + 1;
        if (pmem_mem.exists(addr)) begin
            return pmem_mem[addr];
        end
        return 32'h0;
    endfunction

    function automatic void pmem_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] mask);
        logic [31:0] word;
        pmem_wr_calls = pmem_wr_calls + 1;
        word = pmem_mem.exists(addr) ? pmem_mem[addr] : 32'h0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (mask[b]) begin
                word[8*b +: 8] = data[8*b +: 8];
            end
        end
        pmem_mem[addr] = word;
    endfunction

endpackage

// File: rtl/mem_lat_ctr.sv
// rtl/mem_lat_ctr.sv - loadable down-counter with zero flag for channel access latency
module mem_lat_ctr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_dpi_hs.sv
// rtl/mem_dpi_hs.sv - handshaked pmem model with independent read/write channels and latencies
module mem_dpi_hs
    import mem_dpi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rreq_valid,
    output logic                      rreq_ready,
    input  logic [31:0]               rreq_addr,
    output logic                      rresp_valid,
    input  logic                      rresp_ready,
    output logic [DATA_W-1:0]         rresp_data,
    input  logic                      wreq_valid,
    output logic                      wreq_ready,
    input  logic [31:0]               wreq_addr,
    input  logic [DATA_W-1:0]         wreq_data,
    input  logic [strb_w(DATA_W)-1:0] wreq_mask,
    output logic                      bresp_valid,
    input  logic                      bresp_ready
);

    localparam int          NWORDS     = DATA_W / 32;
    localparam int          LINE_BYTES = strb_w(DATA_W);
    localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_BYTES) - 32'd1);
    localparam int          RD_LOAD_I  = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam int          WR_LOAD_I  = (WR_LAT > 1) ? WR_LAT - 2 : 0;

    rd_state_t              r_rd_state, w_rd_next;
    wr_state_t              r_wr_state, w_wr_next;
    logic [31:0]            r_rd_addr, r_wr_addr;
    logic [DATA_W-1:0]      r_wr_data, r_rdata;
    logic [LINE_BYTES-1:0]  r_wr_mask;
    logic                   w_rd_accept, w_rd_fire, w_rd_load, w_rd_dec, w_rd_zero;
    logic                   w_wr_accept, w_wr_fire, w_wr_load, w_wr_dec, w_wr_zero;
    logic [31:0]            w_rd_addr, w_wr_addr;
    logic [DATA_W-1:0]      w_wr_data;
    logic [LINE_BYTES-1:0]  w_wr_mask;

    mem_lat_ctr #(.CNT_W(CNT_W)) u_rd_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_rd_load),
        .i_load_val (CNT_W'(RD_LOAD_I)),
        .i_dec      (w_rd_dec),
        .o_zero     (w_rd_zero)
    );

    mem_lat_ctr #(.CNT_W(CNT_W)) u_wr_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_wr_load),
        .i_load_val (CNT_W'(WR_LOAD_I)),
        .i_dec      (w_wr_dec),
        .o_zero     (w_wr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_rd_next   = r_rd_state;
        w_rd_accept = 1'b0;
        w_rd_fire   = 1'b0;
        w_rd_load   = 1'b0;
        w_rd_dec    = 1'b0;
        case (r_rd_state)
            R_IDLE: if (rreq_valid) begin
                w_rd_accept = 1'b1;
                if (RD_LAT == 1) begin
                    w_rd_fire = 1'b1;
                    w_rd_next = R_RESP;
                end else begin
                    w_rd_load = 1'b1;
                    w_rd_next = R_WAIT;
                end
            end
            R_WAIT: if (w_rd_zero) begin
                w_rd_fire = 1'b1;
                w_rd_next = R_RESP;
            end else begin
                w_rd_dec = 1'b1;
            end
            R_RESP: if (rresp_ready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_next   = r_wr_state;
        w_wr_accept = 1'b0;
        w_wr_fire   = 1'b0;
        w_wr_load   = 1'b0;
        w_wr_dec    = 1'b0;
        case (r_wr_state)
            W_IDLE: if (wreq_valid) begin
                w_wr_accept = 1'b1;
                if (WR_LAT == 1) begin
                    w_wr_fire = 1'b1;
                    w_wr_next = W_RESP;
                end else begin
                    w_wr_load = 1'b1;
                    w_wr_next = W_WAIT;
                end
            end
            W_WAIT: if (w_wr_zero) begin
                w_wr_fire = 1'b1;
                w_wr_next = W_RESP;
            end else begin
                w_wr_dec = 1'b1;
            end
            W_RESP: if (bresp_ready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // A latency-1 access fires on the accept edge, so it must see the live request inputs.
    assign w_rd_addr = (r_rd_state == R_IDLE) ? (rreq_addr & ALIGN_MASK) : r_rd_addr;
    assign w_wr_addr = (r_wr_state == W_IDLE) ? (wreq_addr & ALIGN_MASK) : r_wr_addr;
    assign w_wr_data = (r_wr_state == W_IDLE) ? wreq_data : r_wr_data;
    assign w_wr_mask = (r_wr_state == W_IDLE) ? wreq_mask : r_wr_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_mask <= '0;
        end else begin
            if (w_rd_accept) r_rd_addr <= rreq_addr & ALIGN_MASK;
            if (w_wr_accept) begin
                r_wr_addr <= wreq_addr & ALIGN_MASK;
                r_wr_data <= wreq_data;
                r_wr_mask <= wreq_mask;
            end
        end
    end

    function automatic logic [DATA_W-1:0] line_read(input logic [31:0] addr);
        logic [DATA_W-1:0] line;
        line = '0;
        for (int i = 0; i < NWORDS; i++) begin
            line[32*i +: 32] = pmem_read(addr + 32'(WORD_BYTES * i));
        end
        return line;
    endfunction

    function automatic void line_write(input logic [31:0] addr, input logic [DATA_W-1:0] data,
                                       input logic [LINE_BYTES-1:0] mask);
        for (int i = 0; i < NWORDS; i++) begin
            if (mask[4*i +: 4] != 4'b0) begin
                pmem_write(addr + 32'(WORD_BYTES * i), data[32*i +: 32], mask[4*i +: 4]);
            end
        end
    endfunction

    // Write is issued first so a read completing on the same edge observes the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            if (w_wr_fire) line_write(w_wr_addr, w_wr_data, w_wr_mask);
            if (w_rd_fire) r_rdata <= line_read(w_rd_addr);
        end
    end

    assign rreq_ready  = (r_rd_state == R_IDLE) && !rst;
    assign rresp_valid = (r_rd_state == R_RESP) && !rst;
    assign rresp_data  = rst ? '0 : r_rdata;
    assign wreq_ready  = (r_wr_state == W_IDLE) && !rst;
    assign bresp_valid = (r_wr_state == W_RESP) && !rst;

endmodule

// File: tb/tb_mem_dpi_hs.sv
// tb/tb_mem_dpi_hs.sv - randomized self-checking bench for mem_dpi_hs against a byte-level memory model
module tb_mem_dpi_hs;

    logic        clk;
    logic        rst;
    logic [1:0]  rreq_valid, rreq_ready, rresp_valid, rresp_ready;
    logic [1:0]  wreq_valid, wreq_ready, bresp_valid, bresp_ready;
    logic [31:0] rreq_addr [2];
    logic [31:0] wreq_addr [2];
    logic [63:0] wreq_data [2];
    logic [7:0]  wreq_mask [2];
    logic [31:0] rdata_a;
    logic [63:0] rdata_b;

    int n_checks;
    int n_fail;
    logic [7:0] ref_bytes [logic [31:0]];

    mem_dpi_hs #(.DATA_W(32), .RD_LAT(1), .WR_LAT(1), .CNT_W(8)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .rreq_valid  (rreq_valid[0]),
        .rreq_ready  (rreq_ready[0]),
        .rreq_addr   (rreq_addr[0]),
        .rresp_valid (rresp_valid[0]),
        .rresp_ready (rresp_ready[0]),
        .rresp_data  (rdata_a),
        .wreq_valid  (wreq_valid[0]),
        .wreq_ready  (wreq_ready[0]),
        .wreq_addr   (wreq_addr[0]),
        .wreq_data   (wreq_data[0][31:0]),
        .wreq_mask   (wreq_mask[0][3:0]),
        .bresp_valid (bresp_valid[0]),
        .bresp_ready (bresp_ready[0])
    );

    mem_dpi_hs #(.DATA_W(64), .RD_LAT(4), .WR_LAT(3), .CNT_W(8)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .rreq_valid  (rreq_valid[1]),
        .rreq_ready  (rreq_ready[1]),
        .rreq_addr   (rreq_addr[1]),
        .rresp_valid (rresp_valid[1]),
        .rresp_ready (rresp_ready[1]),
        .rresp_data  (rdata_b),
        .wreq_valid  (wreq_valid[1]),
        .wreq_ready  (wreq_ready[1]),
        .wreq_addr   (wreq_addr[1]),
        .wreq_data   (wreq_data[1]),
        .wreq_mask   (wreq_mask[1]),
        .bresp_valid (bresp_valid[1]),
        .bresp_ready (bresp_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rdata(input int d);
        return (d == 0) ? {32'h0, rdata_a} : rdata_b;
    endfunction

    task automatic preload_word(input logic [31:0] a, input logic [31:0] v);
        mem_dpi_pkg::pmem_mem[a] = v;
        for (int j = 0; j < 4; j++) ref_bytes[a + 32'(j)] = v[8*j +: 8];
    endtask

    function automatic logic [63:0] ref_read_line(input int d, input logic [31:0] addr);
        int nb;
        logic [31:0] base;
        logic [63:0] v;
        nb   = (d == 0) ? 4 : 8;
        base = addr - (addr % 32'(nb));
        v    = '0;
        for (int j = 0; j < nb; j++) begin
            if (ref_bytes.exists(base + 32'(j))) v[8*j +: 8] = ref_bytes[base + 32'(j)];
        end
        return v;
    endfunction

    task automatic ref_write(input int d, input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] mask, output int calls);
        int nb;
        logic [31:0] base;
        nb    = (d == 0) ? 4 : 8;
        base  = addr - (addr % 32'(nb));
        calls = 0;
        for (int j = 0; j < nb; j++) if (mask[j]) ref_bytes[base + 32'(j)] = data[8*j +: 8];
        for (int w = 0; w < nb / 4; w++) if (mask[4*w +: 4] != 4'h0) calls++;
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input int hold, output logic [63:0] data);
        int lat, k, calls0;
        logic [63:0] exp;
        lat    = (d == 0) ? 1 : 4;
        exp    = ref_read_line(d, addr);
        calls0 = int'(mem_dpi_pkg::pmem_rd_calls);
        check("rd_req_ready", rreq_ready[d], 1);
        rreq_addr[d]   = addr;
        rreq_valid[d]  = 1'b1;
        rresp_ready[d] = 1'b0;
        @(posedge clk); #1;
        rreq_valid[d] = 1'b0;
        rreq_addr[d]  = $urandom;
        k = 1;
        while (!rresp_valid[d] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("rd_latency", k, lat);
        data = rdata(d);
        check("rd_data", data, exp);
        check("rd_calls", int'(mem_dpi_pkg::pmem_rd_calls) - calls0, (d == 0) ? 1 : 2);
        check("rd_busy", rreq_ready[d], 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("rd_hold_valid", rresp_valid[d], 1);
            check("rd_hold_data", rdata(d), data);
        end
        rresp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rresp_ready[d] = 1'b0;
        check("rd_back_idle", rreq_ready[d], 1);
        check("rd_valid_drop", rresp_valid[d], 0);
        check("rd_data_kept", rdata(d), data);
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] mask, input int hold);
        int lat, k, calls0, exp_calls;
        lat    = (d == 0) ? 1 : 3;
        calls0 = int'(mem_dpi_pkg::pmem_wr_calls);
        check("wr_req_ready", wreq_ready[d], 1);
        wreq_addr[d]   = addr;
        wreq_data[d]   = data;
        wreq_mask[d]   = mask;
        wreq_valid[d]  = 1'b1;
        bresp_ready[d] = 1'b0;
        @(posedge clk); #1;
        wreq_valid[d] = 1'b0;
        wreq_addr[d]  = $urandom;
        wreq_data[d]  = {$urandom, $urandom};
        wreq_mask[d]  = 8'hFF;
        ref_write(d, addr, data, mask, exp_calls);
        k = 1;
        while (!bresp_valid[d] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("wr_latency", k, lat);
        check("wr_calls", int'(mem_dpi_pkg::pmem_wr_calls) - calls0, exp_calls);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("wr_hold_valid", bresp_valid[d], 1);
            check("wr_busy", wreq_ready[d], 0);
        end
        bresp_ready[d] = 1'b1;
        @(posedge clk); #1;
        bresp_ready[d] = 1'b0;
        check("wr_back_idle", wreq_ready[d], 1);
        check("wr_calls_once", int'(mem_dpi_pkg::pmem_wr_calls) - calls0, exp_calls);
    endtask

    task automatic do_rw_same(input int d, input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] exp, got;
        int k, calls;
        logic seen_b;
        wreq_addr[d]   = addr;
        wreq_data[d]   = {data, data};
        wreq_mask[d]   = 8'hFF;
        wreq_valid[d]  = 1'b1;
        rreq_addr[d]   = addr;
        rreq_valid[d]  = 1'b1;
        rresp_ready[d] = 1'b1;
        bresp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rreq_valid[d] = 1'b0;
        wreq_valid[d] = 1'b0;
        ref_write(d, addr, {data, data}, 8'hFF, calls);
        exp    = ref_read_line(d, addr);
        k      = 1;
        seen_b = bresp_valid[d];
        while (!rresp_valid[d] && k < 50) begin
            @(posedge clk); #1;
            k++;
            seen_b = seen_b | bresp_valid[d];
        end
        got = rdata(d);
        check("rw_rvalid", rresp_valid[d], 1);
        check("rw_bvalid_seen", seen_b, 1);
        check("rw_data", got, exp);
        check("rw_new_word", got[31:0], data);
        @(posedge clk); #1;
        rresp_ready[d] = 1'b0;
        bresp_ready[d] = 1'b0;
        check("rw_rready", rreq_ready[d], 1);
        check("rw_wready", wreq_ready[d], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        logic [31:0] a;
        logic [7:0]  m;
        int d, hold, rc0, wc0;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        rreq_valid = '0; rresp_ready = '0; wreq_valid = '0; bresp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            rreq_addr[i] = '0; wreq_addr[i] = '0; wreq_data[i] = '0; wreq_mask[i] = '0;
        end
        mem_dpi_pkg::pmem_rd_calls = 0;
        mem_dpi_pkg::pmem_wr_calls = 0;
        for (int i = 0; i < 64; i++) preload_word(32'h8000_0000 + 32'(4 * i), $urandom);
        preload_word(32'h8000_0000, 32'hDEAD_BEEF);
        preload_word(32'h8000_0010, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_rreq_ready", rreq_ready[i], 0);
            check("rst_wreq_ready", wreq_ready[i], 0);
            check("rst_rresp_valid", rresp_valid[i], 0);
            check("rst_bresp_valid", bresp_valid[i], 0);
            check("rst_rresp_data", rdata(i), 0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("post_rst_rready", rreq_ready[i], 1);
            check("post_rst_wready", wreq_ready[i], 1);
        end
        check("post_rst_rd_calls", mem_dpi_pkg::pmem_rd_calls, 0);
        @(posedge clk); #1;

        do_read(0, 32'h8000_0000, 0, got);
        check("rd_deadbeef", got, 64'hDEAD_BEEF);
        do_read(1, 32'h8000_0004, 3, got);
        check("rd64_align_lo", got[31:0], 32'hDEAD_BEEF);
        do_write(1, 32'h8000_0010, {32'h0, 32'h1122_3344}, 8'h05, 1);
        do_read(1, 32'h8000_0010, 0, got);
        check("wr_merge", got[31:0], 32'hFF22_FF44);
        do_rw_same(0, 32'h8000_0040, 32'hCAFE_F00D);
        do_rw_same(1, 32'h8000_0048, 32'h1234_5678);

        // Abort a read and a write on the 64-bit instance while both are still waiting.
        rc0 = int'(mem_dpi_pkg::pmem_rd_calls);
        wc0 = int'(mem_dpi_pkg::pmem_wr_calls);
        rreq_addr[1] = 32'h8000_0020; rreq_valid[1] = 1'b1;
        wreq_addr[1] = 32'h8000_0020; wreq_data[1] = {$urandom, $urandom};
        wreq_mask[1] = 8'hFF;         wreq_valid[1] = 1'b1;
        @(posedge clk); #1;
        rreq_valid[1] = 1'b0;
        wreq_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_rready", rreq_ready[1], 0);
        check("mid_rst_wready", wreq_ready[1], 0);
        check("mid_rst_rdata_a", rdata(0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_rready_back", rreq_ready[1], 1);
        check("mid_rst_wready_back", wreq_ready[1], 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_rvalid", rresp_valid[1], 0);
            check("mid_rst_no_bvalid", bresp_valid[1], 0);
        end
        check("mid_rst_rd_calls", int'(mem_dpi_pkg::pmem_rd_calls) - rc0, 0);
        check("mid_rst_wr_calls", int'(mem_dpi_pkg::pmem_wr_calls) - wc0, 0);
        do_read(1, 32'h8000_0020, 0, got);

        for (int i = 0; i < 40; i++) begin
            d    = int'($urandom_range(0, 1));
            a    = 32'h8000_0000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            m    = 8'($urandom);
            if (d == 0) m = {4'h0, m[3:0]};
            if ($urandom_range(0, 1) == 1) do_write(d, a, {$urandom, $urandom}, m, hold);
            else do_read(d, a, hold, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
